rounding_unit_normalizer: RTL
=============================

// Module: rounding_unit_normalizer
// PURPOSE
// - Producer side of the rounding-unit fraction interface: normalizes a raw [xx.47] fraction and builds the sticky bit.
// - The rounding selecter consumes its normalized_fraction/sticky_bit output.
// - Sits between the add/mul datapath and rounding.
// - 2-stage valid/ready pipeline: S1 = leading-zero count + shift plan; S2 = shift, sticky OR-reduce, exponent adjust.
// PARAMETERS
// - EXP_WIDTH  10  signed two's-complement exponent width.
// - EXP_MIN    1   smallest normal biased exponent; left shifts never take exponent below it.
// - TAG_WIDTH  4   opaque sideband carried alongside data, unmodified.
// PORTS
// - clk                  in   1          clock; all state on rising edge.
// - reset                in   1          synchronous, active-high.
// - in_valid             in   1          input beat valid.
// - in_ready             out  1          block accepts beat when in_valid && in_ready.
// - in_fraction          in   49         raw fraction [xx.47], bit 48 = carry-out.
// - in_sticky            in   1          OR of bits already discarded upstream (alignment).
// - in_exponent          in   EXP_WIDTH  biased exponent for in_fraction.
// - in_tag               in   TAG_WIDTH  sideband.
// - out_valid            out  1          output beat valid.
// - out_ready            in   1          downstream accept.
// - normalized_fraction  out  49         [xx.47]; bit48=0; bit47=1 unless denormal/zero.
// - sticky_bit           out  1          OR of normalized bits [21:0], in_sticky, and any bit shifted out right.
// - out_exponent         out  EXP_WIDTH  adjusted exponent.
// - out_denormal         out  1          result below normal range (bit47=0, nonzero).
// - out_zero             out  1          in_fraction==0 && in_sticky==0.
// - out_tag              out  TAG_WIDTH  in_tag delayed with data.
// BEHAVIOUR
// - Reset: out_valid=0; stage valids=0; normalized_fraction, sticky_bit, out_exponent, out_denormal, out_zero, out_tag all 0.
// - Reset mid-operation discards all in-flight beats; in_ready=1 in the first cycle after reset deasserts.
// - Latency 2 cycles accept-to-out_valid with no stall; throughput 1 beat/cycle.
// - Stall: stage N advances iff its successor is empty or advancing. in_ready = !s1_valid || s1_advance (combinational from out_ready).
// - Output data holds stable while out_valid && !out_ready. No beat dropped or duplicated.
// - Case A, bit48=1: shift right 1; dropped bit0 ORs into sticky; exponent+1.
// - Case B, bit48=0, bit47=1: no shift.
// - Case C, bit48:47==0, nonzero: lz = leading zeros of [46:0] + 1.
//   - shift = min(lz, in_exponent-EXP_MIN); shift = 0 if in_exponent<=EXP_MIN.
//   - Shift left by shift; exponent -= shift; out_denormal = (result bit47==0).
// - Case D, in_fraction==0: fraction 0, out_exponent 0, out_zero=in_sticky?0:1, sticky_bit=in_sticky.
// - sticky_bit is computed after the shift from final bits [21:0]; bits 23/22 are left intact as guard/round.
// - Exponent arithmetic at EXP_WIDTH+1 bits internally, truncated on output. Overflow is detected downstream, not here.
// - Simultaneous accept and output-handshake on a full pipe: both occur, pipe stays full.
// CONFIGURATION
// - Macro ROUNDING_UNIT_NORMALIZER_FLUSH_TO_ZERO_EN.
// - Defined: any result flagged denormal becomes fraction=0, sticky_bit=0, out_exponent=0, out_zero=1, out_denormal=0.
// - Not defined: denormal results pass through as specified in BEHAVIOUR; out_denormal asserted.
// - Latency and handshake are identical in both builds.
// TESTING
// - Carry: frac=49'h1_8000_0000_0001, exp=100, stall-free
//   -> 2 cycles later frac=49'h0_C000_0000_0000, sticky=1, exp=101.
// - Normal: frac=49'h0_8000_0080_0000, exp=50 -> unchanged frac, exp=50, sticky=0 (bit23 guard kept).
// - Left shift: frac=49'h0_0000_0100_0000 (bit24), exp=127 -> frac bit47 set, exp=104, denormal=0.
// - Denormal clamp: frac=49'h0_0000_0100_0000, exp=5
//   -> shift=4, exp=1, out_denormal=1; FTZ build: frac=0, out_zero=1.
// - Backpressure: 4 back-to-back beats, out_ready low cycles 3-6
//   -> in_ready low once 2 held; all 4 out in order, data stable during stall.
// - Zero and reset: frac=0, sticky=1 -> out_zero=0, sticky=1.
//   Assert reset with 2 beats in flight -> out_valid=0 next cycle, no beat emerges.

Source files
------------

// File: rtl/rounding_unit_normalizer.sv
// Fraction normalizer and sticky builder feeding the rounding selecter; 2-stage valid/ready pipe.
// Build option: define ROUNDING_UNIT_NORMALIZER_FLUSH_TO_ZERO_EN to flush denormal results to zero.
module rounding_unit_normalizer #(
    parameter int EXP_WIDTH = 10,
    parameter int EXP_MIN   = 1,
    parameter int TAG_WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [48:0]          in_fraction,
    input  logic                 in_sticky,
    input  logic [EXP_WIDTH-1:0] in_exponent,
    input  logic [TAG_WIDTH-1:0] in_tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [48:0]          normalized_fraction,
    output logic                 sticky_bit,
    output logic [EXP_WIDTH-1:0] out_exponent,
    output logic                 out_denormal,
    output logic                 out_zero,
    output logic [TAG_WIDTH-1:0] out_tag
);

    localparam int XW = EXP_WIDTH + 1;

    typedef enum logic [1:0] {
        PLAN_RIGHT,
        PLAN_NONE,
        PLAN_LEFT,
        PLAN_ZERO
    } plan_t;

    logic                 s2_accept;
    logic                 s1_load;

    logic [5:0]           lz_cnt;
    logic [5:0]           lz;
    logic signed [XW-1:0] exp_ext;
    logic signed [XW-1:0] exp_room;
    logic [5:0]           shift_amt;
    plan_t                plan;

    logic                 s1_valid;
    plan_t                s1_plan;
    logic [5:0]           s1_shift;
    logic [48:0]          s1_frac;
    logic                 s1_sticky;
    logic [XW-1:0]        s1_exp;
    logic [TAG_WIDTH-1:0] s1_tag;

    logic [48:0]          s2_frac;
    logic [XW-1:0]        s2_exp;
    logic                 s2_shifted_out;
    logic                 s2_sticky;
    logic                 s2_denorm;
    logic                 s2_zero;

    assign s2_accept = !out_valid || out_ready;
    assign in_ready  = !s1_valid || s2_accept;
    assign s1_load   = in_valid && in_ready;

    // Stage 1: classify the beat and plan the shift.
    always_comb begin
        lz_cnt = 6'd47;
        for (int i = 0; i < 47; i++) begin
            if (in_fraction[i]) begin
                lz_cnt = 6'(46 - i);
            end
        end
        lz = lz_cnt + 6'd1;

        exp_ext  = {in_exponent[EXP_WIDTH-1], in_exponent};
        exp_room = exp_ext - XW'(EXP_MIN);

        // Left shift is capped so the exponent never drops below EXP_MIN.
        shift_amt = 6'd0;
        if (!exp_room[XW-1] && (exp_room != '0)) begin
            if (exp_room > $signed({{(XW-6){1'b0}}, lz})) begin
                shift_amt = lz;
            end else begin
                shift_amt = exp_room[5:0];
            end
        end

        if (in_fraction[48]) begin
            plan = PLAN_RIGHT;
        end else if (in_fraction[47]) begin
            plan = PLAN_NONE;
        end else if (in_fraction == '0) begin
            plan = PLAN_ZERO;
        end else begin
            plan = PLAN_LEFT;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid  <= 1'b0;
            s1_plan   <= PLAN_NONE;
            s1_shift  <= '0;
            s1_frac   <= '0;
            s1_sticky <= 1'b0;
            s1_exp    <= '0;
            s1_tag    <= '0;
        end else begin
            if (in_ready) begin
                s1_valid <= in_valid;
            end
            if (s1_load) begin
                s1_plan   <= plan;
                s1_shift  <= shift_amt;
                s1_frac   <= in_fraction;
                s1_sticky <= in_sticky;
                s1_exp    <= exp_ext;
                s1_tag    <= in_tag;
            end
        end
    end

    // Stage 2: apply the shift, adjust the exponent, fold the low bits into sticky.
    always_comb begin
        s2_frac        = s1_frac;
        s2_exp         = s1_exp;
        s2_shifted_out = 1'b0;
        s2_denorm      = 1'b0;
        s2_zero        = 1'b0;

        case (s1_plan)
            PLAN_RIGHT: begin
                s2_frac        = s1_frac >> 1;
                s2_shifted_out = s1_frac[0];
                s2_exp         = s1_exp + XW'(1);
            end
            PLAN_LEFT: begin
                s2_frac   = s1_frac << s1_shift;
                s2_exp    = s1_exp - XW'({1'b0, s1_shift});
                s2_denorm = !s2_frac[47];
            end
            PLAN_ZERO: begin
                s2_frac = '0;
                s2_exp  = '0;
                s2_zero = !s1_sticky;
            end
            default: begin
            end
        endcase

        // Bits 23/22 stay as guard/round; everything below feeds sticky.
        s2_sticky = s1_sticky | s2_shifted_out | (|s2_frac[21:0]);

`ifdef ROUNDING_UNIT_NORMALIZER_FLUSH_TO_ZERO_EN
        if (s2_denorm) begin
            s2_frac   = '0;
            s2_sticky = 1'b0;
            s2_exp    = '0;
            s2_zero   = 1'b1;
            s2_denorm = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid           <= 1'b0;
            normalized_fraction <= '0;
            sticky_bit          <= 1'b0;
            out_exponent        <= '0;
            out_denormal        <= 1'b0;
            out_zero            <= 1'b0;
            out_tag             <= '0;
        end else if (s2_accept) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                normalized_fraction <= s2_frac;
                sticky_bit          <= s2_sticky;
                out_exponent        <= s2_exp[EXP_WIDTH-1:0];
                out_denormal        <= s2_denorm;
                out_zero            <= s2_zero;
                out_tag             <= s1_tag;
            end
        end
    end

endmodule
